// File: rtl/audio_chain_pkg.sv
// Shared types and constants for the effect chain.
// Sequencer state encoding and slot index sizing.
package audio_chain_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    WAIT,
    OUT
  } seq_state_t;

  localparam int DEFAULT_DATA_WIDTH = 16;

  function automatic int slot_idx_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/effect_watchdog.sv
// Per-grant watchdog for the effect chain.
// Flags a slot that holds its turn too long.
module effect_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  assign expired = enable && (count == LAST);

  // count grant cycles, parked at the limit until cleared
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/effect_chain_sequencer.sv
// Walks one sample through the enabled effect slots in order.
// Grants my_turn to one slot at a time and forwards its result.
module effect_chain_sequencer
  import audio_chain_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int NUM_EFFECTS    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sample_valid,
  input  logic [DATA_WIDTH-1:0]           sample_in,
  input  logic [NUM_EFFECTS-1:0]          enable_mask,
  input  logic                            clear_errors,
  output logic [DATA_WIDTH-1:0]           effect_data_in,
  output logic [NUM_EFFECTS-1:0]          effect_cs,
  output logic [NUM_EFFECTS-1:0]          effect_my_turn,
  input  logic [NUM_EFFECTS-1:0]          effect_done,
  input  logic [NUM_EFFECTS*DATA_WIDTH-1:0] effect_data_out,
  output logic [DATA_WIDTH-1:0]           sample_out,
  output logic                            sample_out_valid,
  output logic                            busy,
  output logic                            overrun_err,
  output logic                            timeout_err
);

  localparam int IW = slot_idx_width(NUM_EFFECTS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_EFFECTS);

  seq_state_t state, state_nxt;
  logic [DATA_WIDTH-1:0]  acc;
  logic [IW-1:0]          idx;
  logic [NUM_EFFECTS-1:0] mask;
  logic                   cur_en, cur_done, expired, at_end;
  logic [DATA_WIDTH-1:0]  cur_data;

  assign effect_data_in = acc;
  assign effect_cs      = mask;
  assign at_end         = (idx == LAST_IDX);

  effect_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != WAIT),
    .enable (state == WAIT),
    .expired(expired)
  );

  // select enable, done and result of the current slot
  always_comb begin
    cur_en   = 1'b0;
    cur_done = 1'b0;
    cur_data = '0;
    for (int i = 0; i < NUM_EFFECTS; i++) begin
      if (idx == IW'(i)) begin
        cur_en   = mask[i];
        cur_done = effect_done[i];
        cur_data = effect_data_out[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (sample_valid) state_nxt = SELECT;
      SELECT: begin
        if (at_end)      state_nxt = OUT;
        else if (cur_en) state_nxt = WAIT;
      end
      WAIT:   if (cur_done || expired) state_nxt = SELECT;
      OUT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // grant decode and busy from registered state
  always_comb begin
    busy = (state != IDLE);
    effect_my_turn = '0;
    for (int i = 0; i < NUM_EFFECTS; i++) begin
      effect_my_turn[i] = (state == WAIT) && (idx == IW'(i));
    end
  end

  // datapath: capture, slot advance, result register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc              <= '0;
      idx              <= '0;
      mask             <= '0;
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
    end else begin
      sample_out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sample_valid) begin
            acc  <= sample_in;
            mask <= enable_mask;
            idx  <= '0;
          end
        end
        SELECT: begin
          if (at_end) begin
            sample_out       <= acc;
            sample_out_valid <= 1'b1;
          end else if (!cur_en) begin
            idx <= idx + 1'b1;
          end
        end
        WAIT: begin
          if (cur_done) begin
            acc <= cur_data;
            idx <= idx + 1'b1;
          end else if (expired) begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // sticky error flags; a new error beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (clear_errors) begin
        overrun_err <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (sample_valid && state != IDLE) overrun_err <= 1'b1;
      if (state == WAIT && !cur_done && expired) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_effect_chain_sequencer.sv
// Randomized bench for effect_chain_sequencer with stub effects.
// Expected results come from a slot-by-slot model of the chain.
module tb_effect_chain_sequencer;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int T  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_valid;
  logic [DW-1:0] sample_in;
  logic [N-1:0]  enable_mask;
  logic          clear_errors;
  logic [DW-1:0] effect_data_in;
  logic [N-1:0]  effect_cs;
  logic [N-1:0]  effect_my_turn;
  logic [N-1:0]  effect_done;
  logic [N*DW-1:0] effect_data_out;
  logic [DW-1:0] sample_out;
  logic          sample_out_valid;
  logic          busy;
  logic          overrun_err;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;
  int lat[N];
  int op[N];
  int cnt[N];
  bit te_exp = 0;
  bit ov_exp = 0;

  always #5 clk = ~clk;

  effect_chain_sequencer #(
    .DATA_WIDTH(DW), .NUM_EFFECTS(N), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst),
    .sample_valid(sample_valid), .sample_in(sample_in),
    .enable_mask(enable_mask), .clear_errors(clear_errors),
    .effect_data_in(effect_data_in), .effect_cs(effect_cs),
    .effect_my_turn(effect_my_turn), .effect_done(effect_done),
    .effect_data_out(effect_data_out),
    .sample_out(sample_out), .sample_out_valid(sample_out_valid),
    .busy(busy), .overrun_err(overrun_err),
    .timeout_err(timeout_err)
  );

  function automatic logic [DW-1:0] fx(input int o,
                                       input logic [DW-1:0] x);
    case (o)
      0:       return x + 16'd1;
      1:       return x << 1;
      2:       return -x;
      default: return x ^ 16'h5a5a;
    endcase
  endfunction

  // stub effects: done after lat[i] cycles of my_turn
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++)
      cnt[i] <= effect_my_turn[i] ? cnt[i] + 1 : 0;
  end

  always_comb begin
    effect_done = '0;
    effect_data_out = '0;
    for (int i = 0; i < N; i++) begin
      effect_done[i] = effect_my_turn[i] && (cnt[i] == lat[i]);
      effect_data_out[i*DW +: DW] = fx(op[i], effect_data_in);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic setup(input int l, input int o);
    for (int i = 0; i < N; i++) begin
      lat[i] = l;
      op[i]  = o;
    end
  endtask

  task automatic clear_flags();
    @(negedge clk);
    clear_errors = 1'b1;
    @(posedge clk);
    #1;
    clear_errors = 1'b0;
    te_exp = 0;
    ov_exp = 0;
    chk("clr_timeout", timeout_err, 0);
    chk("clr_overrun", overrun_err, 0);
  endtask

  task automatic run(input logic [DW-1:0] smp, input logic [N-1:0] m,
                     input int ovr_at, input bit clr_to);
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] vout;
    int ec, cyc, vcyc, pulses, bad;
    int hi[N];
    int exp_hi[N];
    bit to, seen;
    a = smp;
    ec = 2;
    to = 0;
    for (int i = 0; i < N; i++) begin
      hi[i] = 0;
      if (m[i]) begin
        exp_hi[i] = (lat[i] >= T) ? T : lat[i] + 1;
        ec += 1 + exp_hi[i];
        if (lat[i] >= T) to = 1;
        else a = fx(op[i], a);
      end else begin
        exp_hi[i] = 0;
        ec += 1;
      end
    end
    seen = 0; pulses = 0; bad = 0; vcyc = 0; vout = '0;
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in = smp;
    enable_mask = m;
    @(posedge clk);
    cyc = 1;
    #1;
    while (cyc < 200) begin
      sample_valid = 1'b0;
      clear_errors = 1'b0;
      if ($countones(effect_my_turn) > 1) bad++;
      for (int i = 0; i < N; i++) if (effect_my_turn[i]) hi[i]++;
      if (sample_out_valid) begin
        pulses++;
        if (!seen) begin
          seen = 1;
          vcyc = cyc;
          vout = sample_out;
        end
      end
      if (cyc == ovr_at) begin
        sample_valid = 1'b1;
        sample_in = DW'($urandom);
      end
      if (clr_to)
        for (int i = 0; i < N; i++)
          if (effect_my_turn[i] && hi[i] == T) clear_errors = 1'b1;
      if (seen && cyc >= vcyc + 3) break;
      @(posedge clk);
      cyc++;
      #1;
    end
    sample_valid = 1'b0;
    clear_errors = 1'b0;
    if (to) te_exp = 1;
    if (ovr_at > 0) ov_exp = 1;
    chk("valid_seen", seen, 1);
    chk("sample_out", vout, a);
    chk("latency", vcyc, ec);
    chk("pulses", pulses, 1);
    chk("onehot", bad, 0);
    for (int i = 0; i < N; i++)
      chk($sformatf("turn_cnt%0d", i), hi[i], exp_hi[i]);
    chk("hold", $signed(sample_out), a);
    chk("cs", effect_cs, m);
    chk("idle", busy, 0);
    chk("timeout_err", timeout_err, te_exp);
    chk("overrun_err", overrun_err, ov_exp);
  endtask

  initial begin
    int p;
    rst = 1'b1;
    sample_valid = 1'b0;
    sample_in = '0;
    enable_mask = '0;
    clear_errors = 1'b0;
    setup(1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_turn", effect_my_turn, 0);
    chk("rst_out", sample_out, 0);
    chk("rst_valid", sample_out_valid, 0);
    chk("rst_err", {overrun_err, timeout_err}, 0);
    chk("rst_cs", effect_cs, 0);
    chk("rst_data", effect_data_in, 0);
    rst = 1'b0;

    setup(1, 0);
    run(16'd100, 4'b1111, 0, 0);

    setup(1, 1);
    run(-16'sd300, 4'b0101, 0, 0);

    setup(1, 0);
    lat[2] = 20;
    run(16'd0, 4'b1111, 0, 0);
    clear_flags();

    setup(1, 0);
    run(16'd7, 4'b1111, 5, 0);
    clear_flags();

    setup(1, 0);
    lat[0] = 7;
    run(16'd1234, 4'b1111, 0, 0);

    setup(1, 0);
    lat[1] = 20;
    run(16'd40, 4'b1111, 0, 1);
    clear_flags();

    setup(1, 0);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in = 16'd55;
    enable_mask = 4'b1111;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_turn", effect_my_turn, 4'b0010);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    te_exp = 0;
    ov_exp = 0;
    chk("mid_rst_turn", effect_my_turn, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out", sample_out, 0);
    p = 0;
    for (int k = 0; k < 20; k++) begin
      if (sample_out_valid) p++;
      @(posedge clk);
      #1;
    end
    chk("aborted_no_out", p, 0);
    run(16'd9, 4'b1111, 0, 0);

    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < N; i++) begin
        p = $urandom_range(0, 9);
        lat[i] = (p < 8) ? p % 4 : ((p == 8) ? 7 : 20);
        op[i]  = $urandom_range(0, 3);
      end
      run(DW'($urandom), N'($urandom_range(0, 15)), 0, 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      if (r % 5 == 4) clear_flags();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
